blink_meter: RTL

Receive-side counterpart of the blink LED driver: samples an asynchronous blink/LED-style square wave, measures each full period as high-time and low-time in `clk` cycles, and hands the pair out on a valid/ready interface. It also detects a stuck (non-toggling) input. It sits on the board-test path: the blink generator's pin is looped into `blink_in` so that blink timing can be checked in hardware or in simulation.

---
 rtl/blink_meter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/blink_meter.sv
`default_nettype none
// ============================================================================
//  Module   : blink_meter
//  Purpose  : Measures the high and low time of an asynchronous square wave
//             in clk cycles, publishes each full period on a valid/ready
//             port, and flags an input that has stopped toggling.
//  Revision : 1.0  initial release
// ============================================================================
module blink_meter #(
   parameter int CNT_W   = 24,
   parameter int TIMEOUT = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             blink_in,
   output logic [CNT_W-1:0] meas_high,
   output logic [CNT_W-1:0] meas_low,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             meas_drop,
   output logic             stuck,
   output logic             stuck_level
);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      STUCK = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             sync_meta;
   logic             sync_s;
   logic             sync_d;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] high_cnt_nx;
   logic             complete;
   logic             stuck_set;
   logic             stuck_clr;
   logic             stuck_level_nx;

   // Two-flop synchronizer plus a delay flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync_s    <= 1'b0;
         sync_d    <= 1'b0;
      end else begin
         sync_meta <= blink_in;
         sync_s    <= sync_meta;
         sync_d    <= sync_s;
      end
   end

   assign rise = sync_s & ~sync_d;
   assign fall = ~sync_s & sync_d;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic and counter updates; edges take priority over timeout.
   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      high_cnt_nx    = high_cnt;
      complete       = 1'b0;
      stuck_set      = 1'b0;
      stuck_clr      = 1'b0;
      stuck_level_nx = stuck_level;
      case (state)
         IDLE: begin
            if (rise) begin
               cnt_nx   = CNT_ONE;
               state_nx = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               high_cnt_nx = cnt;
               cnt_nx      = CNT_ONE;
               state_nx    = LOW;
            end else if (cnt == CNT_TIMEOUT) begin
               stuck_set      = 1'b1;
               stuck_level_nx = 1'b1;
               state_nx       = STUCK;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         LOW: begin
            if (rise) begin
               complete = 1'b1;
               cnt_nx   = CNT_ONE;
               state_nx = HIGH;
            end else if (cnt == CNT_TIMEOUT) begin
               stuck_set      = 1'b1;
               stuck_level_nx = 1'b0;
               state_nx       = STUCK;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         STUCK: begin
            // A rise restarts measurement; the interrupted period is dropped.
            if (rise) begin
               stuck_clr = 1'b1;
               cnt_nx    = CNT_ONE;
               state_nx  = HIGH;
            end else if (fall) begin
               stuck_clr = 1'b1;
               state_nx  = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Phase counter and captured high time of the period in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         high_cnt <= '0;
      end else begin
         cnt      <= cnt_nx;
         high_cnt <= high_cnt_nx;
      end
   end

   // Stuck flag and the input level observed when it was raised.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         stuck_level <= stuck_level_nx;
         if (stuck_set) begin
            stuck <= 1'b1;
         end else if (stuck_clr) begin
            stuck <= 1'b0;
         end
      end
   end

   // Output holding register: a new period always loads, overwriting
   // unaccepted data and flagging the loss with a single-cycle drop pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meas_high  <= '0;
         meas_low   <= '0;
         meas_valid <= 1'b0;
         meas_drop  <= 1'b0;
      end else begin
         meas_drop <= complete & meas_valid & ~meas_ready;
         if (complete) begin
            meas_high  <= high_cnt;
            meas_low   <= cnt;
            meas_valid <= 1'b1;
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
